// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse to Kempston bridge: FSM encoding,
// protocol constants, header bit positions and the button mapping helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'b00,
        WAIT_B1 = 2'b01,
        WAIT_B2 = 2'b10
    } ps2_state_e;

    localparam logic [7:0] PS2_ACK = 8'hFA;
    localparam logic [7:0] PS2_BAT = 8'hAA;

    localparam int HDR_LEFT   = 0;
    localparam int HDR_RIGHT  = 1;
    localparam int HDR_MIDDLE = 2;
    localparam int HDR_SYNC   = 3;
    localparam int HDR_XOVF   = 6;
    localparam int HDR_YOVF   = 7;

    localparam int KM_RIGHT  = 0;
    localparam int KM_LEFT   = 1;
    localparam int KM_MIDDLE = 2;

    // Kempston buttons are active-low; unused upper bits read as 1.
    function automatic logic [7:0] kempston_buttons(input logic [7:0] hdr);
        logic [7:0] b;
        b            = 8'hFF;
        b[KM_RIGHT]  = ~hdr[HDR_RIGHT];
        b[KM_LEFT]   = ~hdr[HDR_LEFT];
        b[KM_MIDDLE] = ~hdr[HDR_MIDDLE];
        return b;
    endfunction

endpackage

// File: rtl/ps2_mouse_kempston.sv
// Assembles 3-byte PS/2 mouse packets from the receiver byte stream and keeps
// Kempston-style X/Y position counters and an active-low button byte.
module ps2_mouse_kempston
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 560000,
    parameter int TO_WIDTH       = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_strobe,
    input  logic [7:0] byte_data,
    output logic [7:0] kmouse_x,
    output logic [7:0] kmouse_y,
    output logic [7:0] kmouse_buttons,
    output logic       packet_valid,
    output logic       sync_error
);

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    ps2_state_e          state;
    logic [TO_WIDTH-1:0] to_cnt;
    logic [7:0]          hdr_p0;
    logic signed [7:0]   dx_p0;

    // Raw two's-complement byte added mod 256 equals the 9-bit delta mod 256.
    function automatic logic [7:0] add_delta(input logic [7:0] pos,
                                             input logic signed [7:0] d);
        return pos + 8'(d);
    endfunction

    // Packet capture registers carry no reset; they are only read at commit.
    always_ff @(posedge clk) begin
        if (byte_strobe) begin
            if (state == WAIT_B0 && byte_data[HDR_SYNC])
                hdr_p0 <= byte_data;
            if (state == WAIT_B1)
                dx_p0 <= signed'(byte_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= WAIT_B0;
            to_cnt         <= '0;
            kmouse_x       <= 8'h00;
            kmouse_y       <= 8'h00;
            kmouse_buttons <= 8'hFF;
            packet_valid   <= 1'b0;
            sync_error     <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;
            if (byte_strobe) begin
                to_cnt <= '0;
                case (state)
                    WAIT_B0: begin
                        if (byte_data == PS2_ACK || byte_data == PS2_BAT)
                            state <= WAIT_B0;
                        else if (byte_data[HDR_SYNC])
                            state <= WAIT_B1;
                        else
                            sync_error <= 1'b1;
                    end
                    WAIT_B1: state <= WAIT_B2;
                    WAIT_B2: begin
                        if (!hdr_p0[HDR_XOVF])
                            kmouse_x <= add_delta(kmouse_x, dx_p0);
                        if (!hdr_p0[HDR_YOVF])
                            kmouse_y <= add_delta(kmouse_y, signed'(byte_data));
                        kmouse_buttons <= kempston_buttons(hdr_p0);
                        packet_valid   <= 1'b1;
                        state          <= WAIT_B0;
                    end
                    default: state <= WAIT_B0;
                endcase
            end else if (state != WAIT_B0) begin
                if (to_cnt == TO_LAST) begin
                    state  <= WAIT_B0;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_kempston.sv
// Scoreboard bench for ps2_mouse_kempston: expected packet results are queued
// as bytes are driven and compared when packet_valid pulses.
module tb_ps2_mouse_kempston;

    localparam int TO_CYC = 40;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] b;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       byte_strobe;
    logic [7:0] byte_data;
    logic [7:0] kmouse_x;
    logic [7:0] kmouse_y;
    logic [7:0] kmouse_buttons;
    logic       packet_valid;
    logic       sync_error;

    exp_t       sb_q[$];
    int         n_checks;
    int         n_pass;
    int         n_pv;
    int         n_se;
    logic [7:0] mx, my, mb;

    ps2_mouse_kempston #(.TIMEOUT_CYCLES(TO_CYC), .TO_WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .byte_strobe    (byte_strobe),
        .byte_data      (byte_data),
        .kmouse_x       (kmouse_x),
        .kmouse_y       (kmouse_y),
        .kmouse_buttons (kmouse_buttons),
        .packet_valid   (packet_valid),
        .sync_error     (sync_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && sync_error) n_se++;
        if (rst_n && packet_valid) begin
            exp_t e;
            n_pv++;
            if (sb_q.size() == 0) begin
                check("unexpected_packet_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("pkt_x", kmouse_x, e.x);
                check("pkt_y", kmouse_y, e.y);
                check("pkt_buttons", kmouse_buttons, e.b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        byte_strobe = 1'b1;
        byte_data   = b;
        @(negedge clk);
        byte_strobe = 1'b0;
    endtask

    // Reference packet semantics: overflow suppresses an axis, buttons inverted.
    task automatic model_commit(input logic [7:0] h, input logic [7:0] dx, input logic [7:0] dy);
        if (!h[6]) mx = mx + dx;
        if (!h[7]) my = my + dy;
        mb = {5'b11111, ~h[2], ~h[0], ~h[1]};
        sb_q.push_back('{x: mx, y: my, b: mb});
    endtask

    task automatic send_packet(input logic [7:0] h, input logic [7:0] dx, input logic [7:0] dy);
        send_byte(h);
        send_byte(dx);
        model_commit(h, dx, dy);
        send_byte(dy);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check(tag, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        mx = 8'h00; my = 8'h00; mb = 8'hFF;
        check("rst_x", kmouse_x, 8'h00);
        check("rst_y", kmouse_y, 8'h00);
        check("rst_buttons", kmouse_buttons, 8'hFF);
        check("rst_pv", packet_valid, 1'b0);
        check("rst_se", sync_error, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv0, se0;
        n_checks = 0; n_pass = 0; n_pv = 0; n_se = 0;
        byte_strobe = 1'b0;
        byte_data   = 8'h00;
        rst_n       = 1'b1;
        @(negedge clk);
        do_reset();

        send_packet(8'h09, 8'h05, 8'hFE);
        drain("drain_p1");
        check("p1_x", kmouse_x, 8'h05);
        check("p1_y", kmouse_y, 8'hFE);
        check("p1_buttons", kmouse_buttons, 8'hFD);
        check("p1_pv_count", n_pv, 1);
        check("pv_low_after", packet_valid, 1'b0);

        send_packet(8'h18, 8'hFB, 8'h03);
        drain("drain_p2");
        check("p2_x_wrap", kmouse_x, 8'h00);
        check("p2_y", kmouse_y, 8'h01);
        check("p2_buttons", kmouse_buttons, 8'hFF);

        pv0 = n_pv; se0 = n_se;
        send_byte(8'hFA);
        send_byte(8'hAA);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        check("ack_bat_no_pv", n_pv - pv0, 0);
        check("sync_error_once", n_se - se0, 1);

        send_packet(8'h48, 8'h10, 8'h20);
        drain("drain_xovf");
        check("xovf_x_held", kmouse_x, 8'h00);
        check("xovf_y", kmouse_y, 8'h21);

        // Strobe lands exactly on the expiring cycle and must still count.
        send_byte(8'h08);
        send_byte(8'h01);
        repeat (TO_CYC - 1) @(negedge clk);
        model_commit(8'h08, 8'h01, 8'h02);
        send_byte(8'h02);
        drain("drain_edge");
        check("edge_x", kmouse_x, 8'h01);
        check("edge_y", kmouse_y, 8'h23);

        pv0 = n_pv;
        send_byte(8'h08);
        send_byte(8'h10);
        repeat (TO_CYC) @(negedge clk);
        check("timeout_no_change_x", kmouse_x, 8'h01);
        send_packet(8'h0C, 8'h01, 8'h01);
        drain("drain_timeout");
        check("to_x", kmouse_x, 8'h02);
        check("to_y", kmouse_y, 8'h24);
        check("to_buttons", kmouse_buttons, 8'hFB);
        check("to_pv_count", n_pv - pv0, 1);

        send_byte(8'h09);
        send_byte(8'h05);
        do_reset();
        send_packet(8'h09, 8'h03, 8'h04);
        drain("drain_post_rst");
        check("post_rst_x", kmouse_x, 8'h03);
        check("post_rst_y", kmouse_y, 8'h04);
        check("post_rst_buttons", kmouse_buttons, 8'hFD);

        send_packet(8'h0A, 8'h80, 8'h7F);
        send_packet(8'h89, 8'h02, 8'h55);
        drain("drain_b2b");
        check("b2b_x", kmouse_x, 8'h85);
        check("b2b_y", kmouse_y, 8'h83);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
